// File: rtl/ibex_rf_wipe_pkg.sv
// rtl/ibex_rf_wipe_pkg.sv - shared types and address limits for the register file wipe controller
package ibex_rf_wipe_pkg;

    typedef enum logic [1:0] {
        RF_WIPE_IDLE   = 2'd0,
        RF_WIPE_WIPE   = 2'd1,
        RF_WIPE_VERIFY = 2'd2,
        RF_WIPE_DONE   = 2'd3
    } rf_wipe_state_e;

    localparam int unsigned RF_ADDR_W     = 5;
    // x0 is hard-wired zero, so every sweep starts at x1
    localparam logic [RF_ADDR_W-1:0] RF_FIRST_ADDR = 5'd1;
    localparam logic [RF_ADDR_W-1:0] RF_LAST_RV32I = 5'd31;
    localparam logic [RF_ADDR_W-1:0] RF_LAST_RV32E = 5'd15;

    // Highest architectural register swept for the selected base ISA
    function automatic logic [RF_ADDR_W-1:0] rf_last_addr(input bit rv32e);
        return rv32e ? RF_LAST_RV32E : RF_LAST_RV32I;
    endfunction

endpackage

// File: rtl/ibex_rf_wipe_ctrl.sv
// rtl/ibex_rf_wipe_ctrl.sv - wipes and read-back verifies the register file between write-back and the RF ports
module ibex_rf_wipe_ctrl
    import ibex_rf_wipe_pkg::*;
#(
    parameter bit                   RV32E       = 1'b0,
    parameter int unsigned          DataWidth   = 32,
    parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wipe_req_i,
    input  logic [4:0]           core_waddr_i,
    input  logic [DataWidth-1:0] core_wdata_i,
    input  logic                 core_we_i,
    input  logic [4:0]           core_raddr_i,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 rf_we_o,
    output logic [4:0]           rf_raddr_o,
    input  logic [DataWidth-1:0] rf_rdata_i,
    output logic                 busy_o,
    output logic                 core_stall_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam logic [RF_ADDR_W-1:0] LAST = rf_last_addr(RV32E);

    rf_wipe_state_e         r_state;
    logic [RF_ADDR_W-1:0]   r_cnt;
    logic                   r_err;

    logic                   w_idle;
    logic                   w_last;
    logic                   w_mismatch;
    logic                   w_core_we_bad;

    assign w_idle        = (r_state == RF_WIPE_IDLE);
    assign w_last        = (r_cnt == LAST);
    assign w_mismatch    = (r_state == RF_WIPE_VERIFY) && (rf_rdata_i != WordZeroVal);
    assign w_core_we_bad = !w_idle && core_we_i;

    // Sequencer: sweep x1..LAST with the wipe pattern, then read each back; errors are sticky until the next accepted wipe
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= RF_WIPE_IDLE;
            r_cnt   <= RF_FIRST_ADDR;
            r_err   <= 1'b0;
        end else begin
            if (w_mismatch || w_core_we_bad) begin
                r_err <= 1'b1;
            end
            case (r_state)
                RF_WIPE_IDLE: begin
                    if (wipe_req_i) begin
                        r_state <= RF_WIPE_WIPE;
                        r_cnt   <= RF_FIRST_ADDR;
                        r_err   <= 1'b0;
                    end
                end
                RF_WIPE_WIPE: begin
                    if (w_last) begin
                        r_state <= RF_WIPE_VERIFY;
                        r_cnt   <= RF_FIRST_ADDR;
                    end else begin
                        r_cnt   <= r_cnt + 5'd1;
                    end
                end
                RF_WIPE_VERIFY: begin
                    if (w_last) begin
                        r_state <= RF_WIPE_DONE;
                        r_cnt   <= RF_FIRST_ADDR;
                    end else begin
                        r_cnt   <= r_cnt + 5'd1;
                    end
                end
                default: begin
                    r_state <= RF_WIPE_IDLE;
                end
            endcase
        end
    end

    // Port steering: transparent in IDLE; otherwise the sweep owns both RF ports and core writes are dropped
    always_comb begin
        rf_waddr_o = core_waddr_i;
        rf_wdata_o = core_wdata_i;
        rf_we_o    = core_we_i;
        rf_raddr_o = core_raddr_i;
        case (r_state)
            RF_WIPE_WIPE: begin
                rf_waddr_o = r_cnt;
                rf_wdata_o = WordZeroVal;
                rf_we_o    = 1'b1;
                rf_raddr_o = r_cnt;
            end
            RF_WIPE_VERIFY: begin
                rf_waddr_o = r_cnt;
                rf_wdata_o = WordZeroVal;
                rf_we_o    = 1'b0;
                rf_raddr_o = r_cnt;
            end
            RF_WIPE_DONE: begin
                rf_we_o    = 1'b0;
            end
            default: begin
            end
        endcase
    end

    assign busy_o       = !w_idle;
    assign core_stall_o = !w_idle;
    assign done_o       = (r_state == RF_WIPE_DONE);
    assign err_o        = r_err;

endmodule

// File: doc/ibex_rf_wipe_ctrl.md
IBEX_RF_WIPE_CTRL -- requirements
Module: ibex_rf_wipe_ctrl

Interface
REQ-001 The block SHALL have parameter RV32E, default 0, meaning 15 architectural registers when 1, otherwise 31.
REQ-002 The block SHALL have parameter DataWidth, default 32, meaning the register word width.
REQ-003 The block SHALL have parameter WordZeroVal, default '0, meaning the wipe pattern and expected read-back value.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports declared as follows.
- clk_i  input  1  clock; every flop samples on its rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- wipe_req_i  input  1  level request to start a wipe, sampled only in IDLE.
- core_waddr_i  input  5  core write-back address.
- core_wdata_i  input  DataWidth  core write-back data.
- core_we_i  input  1  core write-back enable.
- core_raddr_i  input  5  core read-port-B address.
- rf_waddr_o  output  5  register file write address.
- rf_wdata_o  output  DataWidth  register file write data.
- rf_we_o  output  1  register file write enable.
- rf_raddr_o  output  5  register file read-port-B address.
- rf_rdata_i  input  DataWidth  register file read-port-B data, combinational from rf_raddr_o.
- busy_o  output  1  wipe or verify in progress.
- core_stall_o  output  1  core must hold write-back and read-port-B use.
- done_o  output  1  single-cycle completion pulse.
- err_o  output  1  sticky verify or protocol error.

Function
REQ-005 The FSM SHALL have states IDLE, WIPE, VERIFY and DONE.
REQ-006 In IDLE, rf_waddr_o, rf_wdata_o and rf_we_o SHALL equal core_waddr_i, core_wdata_i and core_we_i, and rf_raddr_o SHALL equal core_raddr_i.
- These are combinational pass-throughs with zero latency.
REQ-007 In IDLE, wipe_req_i=1 SHALL move the FSM to WIPE on the next edge with the address counter at 1.
- A core write in that same cycle is still passed through and completes.
REQ-008 Each WIPE cycle SHALL drive rf_we_o=1, rf_waddr_o=counter and rf_wdata_o=WordZeroVal, then increment the counter.
REQ-009 The last address is LAST = 31 (RV32E=0) or 15 (RV32E=1).
- After the WIPE write to LAST, the FSM SHALL enter VERIFY with the counter reset to 1.
REQ-010 Each VERIFY cycle SHALL drive rf_raddr_o=counter and rf_we_o=0, and compare rf_rdata_i against WordZeroVal.
- A mismatch SHALL set err_o on the next edge.
REQ-011 After verifying LAST, the FSM SHALL enter DONE.
- DONE SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-012 Total latency from the accepting edge to done_o high SHALL be 2*LAST cycles (62, or 30 for RV32E), plus the DONE cycle.
REQ-013 busy_o and core_stall_o SHALL be 1 in WIPE, VERIFY and DONE, and 0 in IDLE.
REQ-014 core_we_i=1 in any non-IDLE state SHALL be dropped, never forwarded, and SHALL set err_o on the next edge.
REQ-015 wipe_req_i in any non-IDLE state SHALL be ignored.
- A still-high wipe_req_i SHALL start a new wipe from IDLE.
REQ-016 err_o SHALL stay set until a new wipe is accepted, and SHALL clear on that accepting edge.
REQ-017 The counter SHALL be ADDR width (5 bits, or 4 bits zero-extended for RV32E) and SHALL never address register 0.

Reset
REQ-018 Assertion of rst_ni SHALL immediately force IDLE, counter=1, err_o=0 and done_o=0.
- busy_o and core_stall_o SHALL read 0 during reset.
REQ-019 Reset during WIPE or VERIFY SHALL abandon the operation; it SHALL NOT be resumed after reset.
REQ-020 Outputs after reset deassertion SHALL follow IDLE pass-through rules from the first clock.

Structure
REQ-021 The state enum type rf_wipe_state_e SHALL reside in shared package ibex_rf_wipe_pkg.
REQ-022 The LAST-address localparam derivation SHALL also reside in ibex_rf_wipe_pkg.
REQ-023 The block SHALL be a single module with no sub-module, and SHALL sit between the write-back stage and the register file write and read-B ports.

Verification
REQ-024 Scenario: fill x1..x31 with 0xDEADBEEF, pulse wipe_req_i -> 31 writes of 0 to addresses 1..31, 31 verify reads, done_o after 62 cycles, err_o=0.
REQ-025 Scenario: RV32E=1 with the same stimulus -> addresses 1..15 only, done_o after 30 cycles.
REQ-026 Scenario: force rf_rdata_i=0x1 during verify of x7 -> err_o=1 after that cycle, and it stays 1 through IDLE until the next wipe is accepted.
REQ-027 Scenario: core_we_i=1, core_waddr_i=5 in the WIPE cycle for x3 -> rf_waddr_o=3, rf_wdata_o=0, err_o=1.
REQ-028 Scenario: assert rst_ni low in the WIPE cycle for x10 -> busy_o=0 immediately; after release, IDLE pass-through with no further wipe writes.
REQ-029 Scenario: wipe_req_i and core_we_i (addr 4, data 0x55) both high in IDLE -> write to x4 with 0x55 passes this cycle, and the WIPE write to x1 follows on the next cycle.
